lcd_pixel_feeder: RTL and testbench

- Datapath stage directly downstream of the LCD timing generator.
- Accepts an AXI4-Stream pixel stream, buffers it in a FIFO, and triggers the timing generator once the frame is primed.
- Drives registered RGB, DE, HSYNC and VSYNC to the panel.
- Detects underflow and stream framing errors.

---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_pixel_fifo.sv | 59 +++++
 rtl/lcd_pixel_feeder.sv | 190 +++++++++++++++++++
 tb/tb_lcd_pixel_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: feeder state encoding, pixel type and panel geometry
// defaults common to the pixel feeder and the timing generator.
package lcd_pkg;

    localparam int LCD_DATA_W        = 24;
    localparam int LCD_H_PIXEL_COUNT = 800;
    localparam int LCD_V_PIXEL_COUNT = 480;

    typedef logic [LCD_DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_FILL   = 3'd2,
        ST_START  = 3'd3,
        ST_STREAM = 3'd4,
        ST_DRAIN  = 3'd5
    } feeder_state_e;

endpackage

// File: rtl/lcd_pixel_fifo.sv
// First-word-fall-through pixel FIFO with single-cycle flush; push is ignored
// when full and pop is ignored when empty.
module lcd_pixel_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign level     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full & ~flush;
    assign do_pop_s  = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_r + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/lcd_pixel_feeder.sv
// AXI4-Stream to LCD panel pixel feeder: buffers a frame start, kicks the timing
// generator, then streams registered RGB/DE/HSYNC/VSYNC. Optional line-length
// checking is compiled in with LCD_PIXEL_FEEDER_TLAST_CHECK_EN.
module lcd_pixel_feeder
    import lcd_pkg::*;
#(
    parameter int                DATA_W        = LCD_DATA_W,
    parameter int                FIFO_DEPTH    = 64,
    parameter int                FILL_LEVEL    = 32,
    parameter int                H_PIXEL_COUNT = LCD_H_PIXEL_COUNT,
    parameter logic [DATA_W-1:0] BLANK_COLOR   = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              enable_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              busy_i,
    output logic              start_o,
    output logic [DATA_W-1:0] lcd_data_o,
    output logic              lcd_de_o,
    output logic              lcd_hsync_o,
    output logic              lcd_vsync_o,
    output logic              underflow_o,
    output logic              sof_err_o,
`ifdef LCD_PIXEL_FEEDER_TLAST_CHECK_EN
    output logic              line_err_o,
`endif
    input  logic              clr_err_i
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FILL_CNT = (AW+1)'(FILL_LEVEL);

    feeder_state_e     state_r, next_state_s;
    logic              busy_q_r;
    logic              beat_s, tready_s, push_s, pop_s, flush_s;
    logic              uf_set_s, sof_set_s;
    logic [DATA_W-1:0] head_s;
    logic              full_s, empty_s;
    logic [AW:0]       level_s;
    logic              start_r, de_r, hsync_r, vsync_r, underflow_r, sof_err_r;
    logic [DATA_W-1:0] data_r;

    assign beat_s        = s_axis_tvalid & tready_s;
    assign s_axis_tready = tready_s;

    lcd_pixel_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_i), .rst(rst_i), .push(push_s), .wdata(s_axis_tdata),
        .pop(pop_s), .flush(flush_s), .head(head_s), .full(full_s),
        .empty(empty_s), .level(level_s)
    );

    // State register plus the delayed busy used for falling-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            busy_q_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            busy_q_r <= busy_i;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = ST_SYNC;
            ST_SYNC:   if (beat_s && s_axis_tuser) next_state_s = ST_FILL;
                       else                        next_state_s = ST_SYNC;
            ST_FILL:   if (level_s >= FILL_CNT) next_state_s = ST_START;
                       else                     next_state_s = ST_FILL;
            ST_START:  next_state_s = ST_STREAM;
            ST_STREAM: if (busy_q_r && !busy_i) next_state_s = ST_DRAIN;
                       else                     next_state_s = ST_STREAM;
            ST_DRAIN:  next_state_s = ST_SYNC;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Per-state stream handshake, FIFO control and error-set strobes.
    always_comb begin
        tready_s  = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        flush_s   = 1'b0;
        uf_set_s  = 1'b0;
        sof_set_s = 1'b0;
        case (state_r)
            ST_SYNC: begin
                tready_s = 1'b1;
                push_s   = beat_s & s_axis_tuser;
            end
            ST_FILL, ST_START: begin
                tready_s = ~full_s;
                push_s   = beat_s;
            end
            ST_STREAM: begin
                tready_s  = ~full_s;
                push_s    = beat_s;
                pop_s     = enable_i & ~empty_s;
                uf_set_s  = enable_i & empty_s;
                sof_set_s = beat_s & s_axis_tuser;
            end
            ST_DRAIN: flush_s = 1'b1;
            default:  tready_s = 1'b0;
        endcase
    end

    // Panel outputs, start pulse and sticky flags; clear wins over set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r      <= BLANK_COLOR;
            de_r        <= 1'b0;
            hsync_r     <= 1'b1;
            vsync_r     <= 1'b1;
            start_r     <= 1'b0;
            underflow_r <= 1'b0;
            sof_err_r   <= 1'b0;
        end else begin
            data_r      <= pop_s ? head_s : BLANK_COLOR;
            de_r        <= enable_i;
            hsync_r     <= hsync_i;
            vsync_r     <= vsync_i;
            start_r     <= (next_state_s == ST_START);
            underflow_r <= clr_err_i ? 1'b0 : (underflow_r | uf_set_s);
            sof_err_r   <= clr_err_i ? 1'b0 : (sof_err_r | sof_set_s);
        end
    end

    assign lcd_data_o  = data_r;
    assign lcd_de_o    = de_r;
    assign lcd_hsync_o = hsync_r;
    assign lcd_vsync_o = vsync_r;
    assign start_o     = start_r;
    assign underflow_o = underflow_r;
    assign sof_err_o   = sof_err_r;

`ifdef LCD_PIXEL_FEEDER_TLAST_CHECK_EN
    localparam int          CW       = (H_PIXEL_COUNT > 1) ? $clog2(H_PIXEL_COUNT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(H_PIXEL_COUNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] pix_cnt_r, pix_idx_s, pix_cnt_nxt_s;
    logic          line_set_s, line_err_r;

    // Index of the pushed pixel within its line; a frame start restarts at zero.
    always_comb begin
        pix_idx_s     = s_axis_tuser ? {CW{1'b0}} : pix_cnt_r;
        line_set_s    = 1'b0;
        pix_cnt_nxt_s = pix_cnt_r;
        if (push_s) begin
            if (s_axis_tlast) begin
                line_set_s    = (pix_idx_s != LAST_IDX);
                pix_cnt_nxt_s = {CW{1'b0}};
            end else if (pix_idx_s == LAST_IDX) begin
                line_set_s    = 1'b1;
                pix_cnt_nxt_s = {CW{1'b0}};
            end else begin
                pix_cnt_nxt_s = pix_idx_s + CNT_ONE;
            end
        end else begin
            pix_cnt_nxt_s = pix_cnt_r;
        end
    end

    // Line counter and sticky line-length error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_cnt_r  <= {CW{1'b0}};
            line_err_r <= 1'b0;
        end else begin
            pix_cnt_r  <= pix_cnt_nxt_s;
            line_err_r <= clr_err_i ? 1'b0 : (line_err_r | line_set_s);
        end
    end

    assign line_err_o = line_err_r;
`else
    logic unused_tlast_s;
    assign unused_tlast_s = s_axis_tlast;
`endif

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Directed bench for lcd_pixel_feeder (H=4, depth 8, fill level 4); line checks
// are exercised when LCD_PIXEL_FEEDER_TLAST_CHECK_EN is defined.
module tb_lcd_pixel_feeder;

    localparam logic [23:0] BLANK = 24'h123456;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] tdata = 24'h000000;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
    logic        tready;
    logic        enable = 1'b0, hsync = 1'b1, vsync = 1'b1, busy = 1'b0, clr = 1'b0;
    logic        start, de, hs_o, vs_o, uf, sof_err;
    logic [23:0] data;
`ifdef LCD_PIXEL_FEEDER_TLAST_CHECK_EN
    logic        line_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lcd_pixel_feeder #(
        .DATA_W(24), .FIFO_DEPTH(8), .FILL_LEVEL(4), .H_PIXEL_COUNT(4), .BLANK_COLOR(BLANK)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tuser(tuser), .s_axis_tlast(tlast),
        .enable_i(enable), .hsync_i(hsync), .vsync_i(vsync), .busy_i(busy),
        .start_o(start), .lcd_data_o(data), .lcd_de_o(de),
        .lcd_hsync_o(hs_o), .lcd_vsync_o(vs_o),
        .underflow_o(uf), .sof_err_o(sof_err),
`ifdef LCD_PIXEL_FEEDER_TLAST_CHECK_EN
        .line_err_o(line_err),
`endif
        .clr_err_i(clr)
    );

    typedef struct packed {
        logic        en, hs, vs, clr;
        logic        de_e;
        logic [23:0] data_e;
        logic        hs_e, vs_e, uf_e;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [23:0] d, input logic u, input logic l);
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        tick();
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            en    hs    vs    clr   de_e  data_e        hs_e  vs_e  uf_e
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h00000A, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00000B, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h00000C, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h00000D, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BLANK,      1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BLANK,      1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BLANK,      1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, BLANK,      1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BLANK,      1'b1, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BLANK,      1'b1, 1'b1, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data, BLANK);
        check("rst_de", de, 1'b0);
        check("rst_hsync", hs_o, 1'b1);
        check("rst_vsync", vs_o, 1'b1);
        check("rst_start", start, 1'b0);
        check("rst_underflow", uf, 1'b0);
        check("rst_sof_err", sof_err, 1'b0);
        check("rst_tready", tready, 1'b0);
        rst = 1'b0;
        tick();
        check("sync_tready", tready, 1'b1);

        // Three beats without tuser are dropped, then a primed 4-pixel line
        for (int i = 1; i <= 3; i++) beat(24'h000E00 + 24'(i), 1'b0, 1'b0);
        beat(24'h00000A, 1'b1, 1'b0);
        check("fill_tready", tready, 1'b1);
        beat(24'h00000B, 1'b0, 1'b0);
        beat(24'h00000C, 1'b0, 1'b0);
        beat(24'h00000D, 1'b0, 1'b1);
        check("start_after_push", start, 1'b0);
        tick();
        check("start_pulse", start, 1'b1);
        tick();
        check("start_cleared", start, 1'b0);
        busy = 1'b1;

        // Output pipeline, underflow and clear-priority vectors
        for (int i = 0; i < 10; i++) begin
            enable = vecs[i].en;
            hsync  = vecs[i].hs;
            vsync  = vecs[i].vs;
            clr    = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_de", i), de, vecs[i].de_e);
            check($sformatf("vec%0d_data", i), data, vecs[i].data_e);
            check($sformatf("vec%0d_hsync", i), hs_o, vecs[i].hs_e);
            check($sformatf("vec%0d_vsync", i), vs_o, vecs[i].vs_e);
            check($sformatf("vec%0d_underflow", i), uf, vecs[i].uf_e);
        end
        enable = 1'b0;
        clr    = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        check("no_sof_err_frame1", sof_err, 1'b0);

        // Fill to full, then offer a beat while popping in the same cycle
        for (int k = 1; k <= 8; k++) beat(24'(k), 1'b0, (k == 4 || k == 8) ? 1'b1 : 1'b0);
        check("full_tready", tready, 1'b0);
        tdata  = 24'h000099;
        tvalid = 1'b1;
        enable = 1'b1;
        #1;
        check("full_pop_tready", tready, 1'b0);
        tick();
        tvalid = 1'b0;
        enable = 1'b0;
        check("full_pop_data", data, 24'h000001);
        check("after_pop_tready", tready, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            enable = 1'b1;
            tick();
            check($sformatf("drain_pix%0d", k), data, 24'(k));
        end
        tick();
        check("seven_left_underflow_data", data, BLANK);
        check("seven_left_underflow", uf, 1'b1);
        enable = 1'b0;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        check("underflow_cleared", uf, 1'b0);

        // Busy falling edge with two pixels buffered
        beat(24'h000021, 1'b0, 1'b0);
        beat(24'h000022, 1'b0, 1'b0);
        busy = 1'b0;
        tick();
        check("drain_tready", tready, 1'b0);
        tick();
        check("resync_tready", tready, 1'b1);
        beat(24'h000031, 1'b0, 1'b0);
        beat(24'h000041, 1'b1, 1'b0);
        beat(24'h000042, 1'b0, 1'b0);
        beat(24'h000043, 1'b0, 1'b0);
        beat(24'h000044, 1'b0, 1'b1);
        tick();
        check("start_frame2", start, 1'b1);
        tick();
        busy   = 1'b1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("frame2_first_pixel", data, 24'h000041);
        check("sof_err_before", sof_err, 1'b0);
        beat(24'h000055, 1'b1, 1'b0);
        check("sof_err_mid_stream", sof_err, 1'b1);
`ifdef LCD_PIXEL_FEEDER_TLAST_CHECK_EN
        check("line_err_good_lines", line_err, 1'b0);
        beat(24'h000056, 1'b0, 1'b0);
        beat(24'h000057, 1'b0, 1'b1);
        check("line_err_short_line", line_err, 1'b1);
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sof_err_cleared", sof_err, 1'b0);
`ifdef LCD_PIXEL_FEEDER_TLAST_CHECK_EN
        check("line_err_cleared", line_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
